// File: rtl/periph_bus_arbiter.sv
// Purpose : two-master arbiter serialising register accesses onto the single-cycle peripheral bus.
// Latency : request seen in IDLE at cycle N -> bus strobe in N+1 -> ack + read data in N+2.
// Backpr. : one access per 3 cycles; requests are ignored outside IDLE, so a master holds req until ack.
// Ports   : clk/reset (sync, active-high); m0_*/m1_* master request/ack/data;
//           p_rd/p_wr/p_addr/p_wdata to the peripheral block, p_rdata combinational back;
//           busy = FSM not idle, owner = current or last granted master.
module periph_bus_arbiter #(
    parameter int PRIO_MODE = 0,    // 0 = round-robin, 1 = fixed priority (master 0 wins)
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              p_rd,
    output logic              p_wr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic              win;
    logic              p_rd_nxt;
    logic              p_wr_nxt;
    logic [ADDR_W-1:0] p_addr_nxt;
    logic [DATA_W-1:0] p_wdata_nxt;
    logic              m0_ack_nxt;
    logic              m1_ack_nxt;
    logic [DATA_W-1:0] m0_rdata_nxt;
    logic [DATA_W-1:0] m1_rdata_nxt;
    logic              owner_nxt;

    // Winner selection. With both requesting, round-robin hands the grant to
    // whichever master did not have it last; a lone requester always wins.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = (PRIO_MODE != 0) ? 1'b0 : ~owner;
        end else begin
            win = m1_req;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: computes the values every output register takes at the
    // next edge. Strobes and bus fields default to 0 so they are only live
    // during ACCESS; rdata registers default to holding.
    always_comb begin
        p_rd_nxt     = 1'b0;
        p_wr_nxt     = 1'b0;
        p_addr_nxt   = '0;
        p_wdata_nxt  = '0;
        m0_ack_nxt   = 1'b0;
        m1_ack_nxt   = 1'b0;
        m0_rdata_nxt = m0_rdata;
        m1_rdata_nxt = m1_rdata;
        owner_nxt    = owner;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_nxt   = win;
                    p_wr_nxt    = win ? m1_wr : m0_wr;
                    p_rd_nxt    = ~(win ? m1_wr : m0_wr);
                    p_addr_nxt  = win ? m1_addr  : m0_addr;
                    p_wdata_nxt = win ? m1_wdata : m0_wdata;
                end
            end
            ACCESS: begin
                // p_wr still holds the latched direction here; a write
                // returns zero instead of whatever p_rdata happens to show.
                if (owner) begin
                    m1_ack_nxt   = 1'b1;
                    m1_rdata_nxt = p_wr ? '0 : p_rdata;
                end else begin
                    m0_ack_nxt   = 1'b1;
                    m0_rdata_nxt = p_wr ? '0 : p_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers. Reset mid-access clears strobes and acks, aborting
    // the transaction without a completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_rd     <= 1'b0;
            p_wr     <= 1'b0;
            p_addr   <= '0;
            p_wdata  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            busy     <= 1'b0;
            owner    <= 1'b1;   // master 0 wins the first round-robin tie
        end else begin
            p_rd     <= p_rd_nxt;
            p_wr     <= p_wr_nxt;
            p_addr   <= p_addr_nxt;
            p_wdata  <= p_wdata_nxt;
            m0_ack   <= m0_ack_nxt;
            m1_ack   <= m1_ack_nxt;
            m0_rdata <= m0_rdata_nxt;
            m1_rdata <= m1_rdata_nxt;
            busy     <= (state_nxt != IDLE);
            owner    <= owner_nxt;
        end
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master arbiter in front of the peripheral register block at 0x40000000–0x40000014 (timer TH/TL/TCON, LED, switch, digit registers).
- Master 0 is the pipeline CPU memory stage. Master 1 is a UART/DMA engine.
- Serialises their register accesses onto the single-cycle peripheral bus (rd, wr, addr, wdata, combinational rdata).
- Each accepted request produces exactly one bus cycle and returns a one-cycle ack with registered read data.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with master 0 winning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; everything is on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held with m0_wr/addr/wdata until m0_ack.
- m0_wr  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data, valid while m0_ack = 1.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: same directions, widths and meanings for master 1.
- p_rd  out  1  peripheral read strobe.
- p_wr  out  1  peripheral write strobe.
- p_addr  out  ADDR_W  peripheral address.
- p_wdata  out  DATA_W  peripheral write data.
- p_rdata  in  DATA_W  peripheral read data, combinational from p_rd/p_addr.
- busy  out  1  high whenever the state is not IDLE.
- owner  out  1  current or last granted master.

Behaviour:
- Reset (synchronous, active-high), at the next posedge:
  - state = IDLE;
  - p_rd, p_wr = 0; p_addr, p_wdata = 0;
  - m0_ack, m1_ack = 0; m0_rdata, m1_rdata = 0;
  - busy = 0; owner = 1, so master 0 wins the first round-robin tie.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner and latch its wr/addr/wdata. Set owner = winner and go to ACCESS.
  - Round-robin: if both requesters are high, grant the master that is not the current owner. A single requester always wins.
  - PRIO_MODE = 1: master 0 wins whenever m0_req = 1.
- ACCESS, exactly one cycle:
  - p_addr and p_wdata carry the latched values. p_rd = ~wr_l and p_wr = wr_l.
  - p_rdata is captured into the owner's rdata register at the end of this cycle. Go to RESP.
- RESP, exactly one cycle:
  - The owner's ack = 1.
  - For a read, owner rdata = the captured value. For a write, owner rdata = 0.
  - p_rd, p_wr = 0 and p_addr, p_wdata = 0. Go to IDLE.
- The loser's ack stays 0 and its rdata holds its previous value.
- Latency: request seen in IDLE at cycle N → bus strobe in N+1 → ack in N+2.
- Throughput: at most one access per 3 cycles.
- p_wr is high for exactly one cycle per write; duplicate writes to the timer or LED registers are forbidden.
- Requests are not sampled in ACCESS or RESP. Any req that is still high when the FSM returns to IDLE is a new transaction; back-to-back requests are therefore legal.
- If the owner drops req during ACCESS or RESP, the access still completes and ack still pulses, because write side effects are not revocable.
- Address decode is not done here. Unmapped addresses pass through, and reads return whatever p_rdata drives (0 for unmapped).
- Reset asserted during ACCESS or RESP aborts the access: no ack is issued, and all strobes are 0 from the next edge.
- Round-robin fairness: with both requesters continuously high, grants alternate 0, 1, 0, 1, …

Test Plan:
- Reset, then m0 read of 0x40000010 with p_rdata = 0x000000A5 → p_rd = 1 at N+1, m0_ack = 1 and m0_rdata = 0x000000A5 at N+2, m1_ack = 0 throughout.
- m1 write of 0x0000003C to 0x4000000C → exactly one cycle with p_wr = 1, p_addr = 0x4000000C, p_wdata = 0x3C, then m1_ack = 1 with m1_rdata = 0.
- Both requesting continuously, 4 transactions each, PRIO_MODE = 0 → grant order m0, m1, m0, m1, …; each ack 6 cycles apart per master.
- Same stimulus with PRIO_MODE = 1 → m0 served every 3 cycles; m1 never acked while m0_req is held.
- m0 issues a write to 0x40000008 and drops m0_req in the ACCESS cycle → p_wr still pulses once and m0_ack still pulses.
- reset asserted in the ACCESS cycle of an m1 write → p_wr = 0 from the next edge, no m1_ack, state IDLE, owner = 1.
